key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  N-channel input conditioner for asynchronous push-buttons and switches.
//  - Synchronises each channel through a parametrised flop chain, then debounces it.
//  - Produces a clean level plus single-cycle rise/fall pulses per channel.
//  - Sits between board KEY/SW pins and game control logic (paddle, start/reset FSMs).
//  - Replaces ad-hoc per-key double-flop instances.
// PARAMETERS
//  NUM_CH          4    number of independent input channels (>=1)
//  SYNC_STAGES     2    synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 4    consecutive disagreeing cycles before level accepts change (>=1)
//  REPEAT_DELAY    16   held cycles before first auto-repeat pulse (>=1; KEY_REPEAT_EN only)
//  REPEAT_PERIOD   4    cycles between subsequent auto-repeat pulses (>=1; KEY_REPEAT_EN only)
// PORTS
//  clk      in   1       system clock
//  reset    in   1       synchronous, active-high reset
//  key_i    in   NUM_CH  raw asynchronous inputs, active-high (invert upstream if needed)
//  level_o  out  NUM_CH  debounced level
//  rise_o   out  NUM_CH  1-cycle pulse, debounced 0->1
//  fall_o   out  NUM_CH  1-cycle pulse, debounced 1->0
//  press_o  out  NUM_CH  1-cycle action pulse (rise, plus repeats when enabled)
// BEHAVIOUR
//  - Reset: clk is clk; reset is reset, synchronous, active-high.
//    - All sync flops, counters, level_o, rise_o, fall_o and press_o go to 0.
//    - No pulse is emitted in the reset cycle or in the first cycle after it.
//    - A key already high at reset release is reported as a normal rise once debounced.
//  - Sync: sync[0] <= key_i; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
//  - Debounce counter cnt (width CNT_W), evaluated per clock:
//    - s == level: cnt <= 0.
//    - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s; cnt <= 0.
//    - otherwise: cnt <= cnt + 1.
//    - A glitch shorter than DEBOUNCE_CYCLES (post-sync) never reaches level_o.
//  - Latency: key_i change captured at edge E0 appears on level_o after edge
//    E0 + SYNC_STAGES-1 + DEBOUNCE_CYCLES (defaults: 6th edge counting E0).
//  - Pulses:
//    - rise_o and fall_o are registered and asserted in the same cycle level_o changes.
//    - Each lasts exactly 1 cycle; rise_o and fall_o are never both high on one channel.
//  - Channels are fully independent; simultaneous events on multiple channels all report.
//  - Counters saturate only through the compare above; they never wrap.
// CONFIGURATION
//  - Macro KEY_REPEAT_EN.
//  - Undefined: press_o == rise_o; no repeat logic or REPEAT_* counters are synthesised.
//  - Defined: per-channel FSM {IDLE, HOLD_DELAY, HOLD_REPEAT} with repeat counter rcnt.
//    - IDLE: on rise -> press_o=1, rcnt<=0, go HOLD_DELAY.
//    - HOLD_DELAY: level high, rcnt reaches REPEAT_DELAY-1 -> press_o=1, rcnt<=0,
//      go HOLD_REPEAT.
//    - HOLD_REPEAT: rcnt reaches REPEAT_PERIOD-1 -> press_o=1, rcnt<=0.
//    - Any state: level low -> IDLE, rcnt<=0, no pulse.
//    - Reset -> IDLE.
// STRUCTURE
//  - Package key_cond_pkg:
//    - typedef enum logic [1:0] rep_state_t {IDLE, HOLD_DELAY, HOLD_REPEAT}.
//    - function cnt_width(int max) returning $clog2(max) with minimum 1.
//    - Default parameter constants.
//  - Sub-module key_cond_chan: one channel (sync chain, debounce, pulses, optional FSM).
//  - Top generates NUM_CH instances.
// TESTING (defaults; macro off unless stated)
//  - Reset held 3 cycles with key_i=4'hF:
//    all outputs 0 during reset and 1 cycle after; ch0-3 rise 6 edges after release.
//  - key_i[0] 0->1 held:
//    level_o[0] and rise_o[0] rise on 6th edge; rise_o[0] high exactly 1 cycle;
//    press_o[0] == rise_o[0].
//  - key_i[1] high for 3 cycles then low:
//    level_o[1], rise_o[1] and fall_o[1] stay 0 throughout.
//  - key_i[2] 1->0 after stable high:
//    fall_o[2] pulses once with level_o[2] falling; key_i[3] toggled same cycle reports independently.
//  - reset asserted mid-debounce (cnt=2):
//    cnt clears; level_o stays 0 with no pulse; new press needs full 6 edges.
//  - KEY_REPEAT_EN, key_i[0] held 40 cycles after debounce:
//    press_o[0] at hold cycles 0, 16, 20, 24, ...; stops immediately on release.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types, defaults and helpers for the key conditioner.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat on press_o).
package key_cond_pkg;

    // Per-channel auto-repeat state.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 4;

    // Counter width able to hold 0..max-1, never narrower than one bit.
    function automatic int cnt_width(input int max);
        int w;
        w = $clog2(max);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_cond_chan.sv
// One conditioner channel: synchroniser chain, debounce counter,
// registered rise/fall pulses and the press pulse. Auto-repeat on press_o
// is built only when KEY_REPEAT_EN is defined.
module key_cond_chan
    import key_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic press_o
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Shift the raw key through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Register level, counter and edge pulses together so pulses align with level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef KEY_REPEAT_EN
    localparam int               RCNT_W      = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                         REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);

    rep_state_t        state_q;
    logic [RCNT_W-1:0] rcnt_q;
    logic              press_q;

    // Auto-repeat FSM; decisions use the next level so pulses never outlive the key.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
        end else if (!level_d) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rcnt_q <= '0;
                    if (rise_d) begin
                        press_q <= 1'b1;
                        state_q <= HOLD_DELAY;
                    end else begin
                        press_q <= 1'b0;
                    end
                end
                HOLD_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                        state_q <= HOLD_REPEAT;
                    end else begin
                        press_q <= 1'b0;
                        rcnt_q  <= rcnt_q + RCNT_ONE;
                    end
                end
                HOLD_REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        press_q <= 1'b0;
                        rcnt_q  <= rcnt_q + RCNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rcnt_q  <= '0;
                    press_q <= 1'b0;
                end
            endcase
        end
    end

    assign press_o = press_q;
`else
    // Without auto-repeat, a press is simply the debounced rising edge.
    assign press_o = rise_q;
`endif

endmodule

// File: rtl/key_conditioner.sv
// N-channel conditioner for asynchronous buttons/switches: synchronise,
// debounce, and emit clean level plus rise/fall/press pulses per channel.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat on press_o).
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] key_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] press_o
);

    // Channels are fully independent; one instance each.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        key_cond_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .key_i  (key_i[g]),
            .level_o(level_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g]),
            .press_o(press_o[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (default parameters).
// Behavioural model: key samples are delayed SYNC_STAGES edges, and the level
// flips once the last DEBOUNCE_CYCLES delayed samples all disagree with it.
module tb_key_conditioner;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int RD     = 16;
    localparam int RP     = 4;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] key_i;
    logic [NUM_CH-1:0] level_o;
    logic [NUM_CH-1:0] rise_o;
    logic [NUM_CH-1:0] fall_o;
    logic [NUM_CH-1:0] press_o;

    int vectors     = 0;
    int miscompares = 0;

    key_conditioner #(
        .NUM_CH         (NUM_CH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_i  (key_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .press_o(press_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [NUM_CH-1:0] kh[$];
    logic [DEB-1:0]    sh[NUM_CH];
    int                hold[NUM_CH];
    logic [NUM_CH-1:0] m_level = '0;
    logic [NUM_CH-1:0] m_rise  = '0;
    logic [NUM_CH-1:0] m_fall  = '0;
    logic [NUM_CH-1:0] m_press = '0;
    logic              model_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [NUM_CH-1:0] s_vec;
        logic [NUM_CH-1:0] lv;
        logic [NUM_CH-1:0] rs;
        logic [NUM_CH-1:0] fl;
        logic [NUM_CH-1:0] pr;
        logic [DEB-1:0]    shv;
        int                hd;
        if (reset) begin
            kh.delete();
            for (int i = 0; i < SYNC; i++) kh.push_back('0);
            for (int c = 0; c < NUM_CH; c++) begin
                sh[c]   <= '0;
                hold[c] <= 0;
            end
            m_level     <= '0;
            m_rise      <= '0;
            m_fall      <= '0;
            m_press     <= '0;
            model_valid <= 1'b1;
        end else begin
            s_vec = kh.pop_front();
            kh.push_back(key_i);
            lv = m_level;
            rs = '0;
            fl = '0;
            pr = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                shv = (sh[c] << 1) | DEB'(s_vec[c]);
                if (!lv[c] && (shv == {DEB{1'b1}})) begin
                    lv[c] = 1'b1;
                    rs[c] = 1'b1;
                end else if (lv[c] && (shv == '0)) begin
                    lv[c] = 1'b0;
                    fl[c] = 1'b1;
                end
                hd = 0;
                if (lv[c]) begin
                    hd = rs[c] ? 0 : hold[c] + 1;
`ifdef KEY_REPEAT_EN
                    pr[c] = rs[c] || (hd == RD) || ((hd > RD) && ((hd - RD) % RP == 0));
`else
                    pr[c] = rs[c];
`endif
                end
                sh[c]   <= shv;
                hold[c] <= hd;
            end
            m_level <= lv;
            m_rise  <= rs;
            m_fall  <= fl;
            m_press <= pr;
        end
    end

    // Compare every output against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if ({level_o, rise_o, fall_o, press_o} !== {m_level, m_rise, m_fall, m_press}) begin
                miscompares++;
                $display("FAIL model t=%0t: got lvl=%h r=%h f=%h p=%h expected lvl=%h r=%h f=%h p=%h",
                         $time, level_o, rise_o, fall_o, press_o, m_level, m_rise, m_fall, m_press);
            end
        end
    end

    // ---------------- directed vectors ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        key_i = 4'hF;

        // Reset held three cycles with all keys high.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_outs", {16'h0, level_o, rise_o, fall_o, press_o}, 32'h0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 6) begin
                chk("post_reset_quiet", {16'h0, level_o, rise_o, fall_o, press_o}, 32'h0);
            end else if (k == 6) begin
                chk("rel_level", 32'(level_o), 32'hF);
                chk("rel_rise",  32'(rise_o),  32'hF);
                chk("rel_press", 32'(press_o), 32'hF);
            end else begin
                chk("rel_rise_1cyc", 32'(rise_o), 32'h0);
                chk("rel_level_hold", 32'(level_o), 32'hF);
            end
        end

        // All keys released: falls after six edges.
        key_i = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) chk("all_fall", 32'(fall_o), 32'hF);
            if (k == 7) chk("all_fall_1cyc", 32'(fall_o), 32'h0);
        end

        // key 0 pressed and held; press pattern while held.
        key_i = 4'h1;
        for (int k = 1; k <= 6 + 39; k++) begin
            @(negedge clk);
            if (k == 5) chk("k0_level_early", 32'(level_o[0]), 32'h0);
            if (k == 6) begin
                chk("k0_level", 32'(level_o[0]), 32'h1);
                chk("k0_rise",  32'(rise_o[0]),  32'h1);
            end
            if (k == 7) chk("k0_rise_1cyc", 32'(rise_o[0]), 32'h0);
            if (k >= 6) begin
`ifdef KEY_REPEAT_EN
                chk("k0_press_rep", 32'(press_o[0]),
                    ((k - 6 == 0) || ((k - 6 >= RD) && ((k - 6 - RD) % RP == 0))) ? 32'h1 : 32'h0);
`else
                chk("k0_press_eq_rise", 32'(press_o[0]), 32'(rise_o[0]));
`endif
            end
        end
        key_i = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 6) chk("k0_release_press", 32'(press_o[0]), 32'h0);
            if (k == 6) chk("k0_fall", 32'(fall_o[0]), 32'h1);
        end

        // key 1 glitch of three cycles never reaches the outputs.
        key_i = 4'h2;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 3) key_i = 4'h0;
            chk("k1_glitch", {29'h0, level_o[1], rise_o[1], fall_o[1]}, 32'h0);
        end

        // key 2 falls while key 3 rises on the same cycle.
        key_i = 4'h4;
        wait_cycles(8);
        key_i = 4'h8;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                chk("k2_fall",   32'(fall_o), 32'h4);
                chk("k3_rise",   32'(rise_o), 32'h8);
                chk("k23_level", 32'(level_o), 32'h8);
            end
            if (k == 7) chk("k23_pulses_1cyc", {24'h0, rise_o, fall_o}, 32'h0);
        end
        key_i = 4'h0;
        wait_cycles(8);

        // Reset while key 0 is mid-debounce (counter at 2).
        key_i = 4'h1;
        wait_cycles(4);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_level", 32'(level_o), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 6) chk("mid_reset_quiet", {16'h0, level_o, rise_o, fall_o, press_o}, 32'h0);
            if (k == 6) begin
                chk("mid_reset_level_up", 32'(level_o[0]), 32'h1);
                chk("mid_reset_rise",     32'(rise_o[0]),  32'h1);
            end
        end
        key_i = 4'h0;
        wait_cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
